alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
Two-requester round-robin arbiter and sequencer for the shared Kolache ALU datapath, including its OR-reduction zero-detect tree.
- Accepts one operation at a time from either requester via valid/ready.
- Drives the ALU operand/opcode bus and waits a fixed ALU latency.
- Captures result and zero flag, and returns them to the granted requester through a one-deep response buffer.
- Sits between the two issuing units (e.g. decode and address-gen) and the single ALU instance.

Parameters:
DW, 16, operand/result width in bits
OPW, 3, opcode width in bits
ALU_LAT, 1, cycles from alu_start to valid alu_y/alu_z; legal range 1..15 (1 = combinational ALU)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_op  in  OPW  requester 0 opcode
req0_a  in  DW  requester 0 operand a
req0_b  in  DW  requester 0 operand b
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 consumes result
req1_valid/req1_ready/req1_op/req1_a/req1_b  same as requester 0, for requester 1
rsp1_valid/rsp1_ready  same as requester 0, for requester 1
rsp_y  out  DW  captured result, shared by both response channels
rsp_z  out  1  captured zero flag (alu_z)
alu_start  out  1  one-cycle launch pulse to the ALU
alu_op  out  OPW  registered opcode to the ALU
alu_a  out  DW  registered operand a
alu_b  out  DW  registered operand b
alu_y  in  DW  ALU result
alu_z  in  1  ALU zero flag (OR-tree output inverted)

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE.
  - All outputs 0.
  - Operand, result and wait-counter registers 0.
  - Round-robin pointer favours requester 0.
  - An in-flight op is dropped with no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational, high only for the selected requester; at most one ready per cycle.
  - Selection: only one valid → that requester; both valid → the one not granted last.
  - Handshake at edge T (valid & ready): latch op/a/b into alu_op/alu_a/alu_b, record grant id, load counter = ALU_LAT-1, go WAIT.
- WAIT:
  - alu_start=1 only in the first WAIT cycle (T+1).
  - Both ready outputs 0.
  - Counter decrements each cycle.
  - At counter==0, capture alu_y→rsp_y and alu_z→rsp_z at that edge, then go RESP.
- Latency: rsp valid from cycle T+1+ALU_LAT. Throughput is one op per ALU_LAT+2 cycles minimum.
- RESP:
  - rspN_valid=1 for the granted requester only; rsp_y/rsp_z held stable.
  - On rspN_ready=1: update round-robin pointer to the granted id and go IDLE.
  - A new request is not accepted in the same cycle as the response handshake.
- Held inputs:
  - req valid and operands may change while not accepted; only the values at the handshake edge are used.
  - rsp_ready asserted with rsp_valid low has no effect.
- Operand/opcode values are passed through unmodified; the block does not decode opcodes.
- alu_op/alu_a/alu_b hold their last values outside WAIT (no toggling).

Optional Feature:
Macro ARB_STATS_EN.
- Defined:
  - Adds ports stats_clr in 1, gnt_cnt0 out 16, gnt_cnt1 out 16.
  - gnt_cntN increments on each requester-N accept handshake and saturates at 16'hFFFF.
  - stats_clr=1 zeroes both counters synchronously; clear wins over a same-cycle increment.
  - Both counters reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single op, ALU_LAT=1: req0 op=3'b010 a=16'h00F0 b=16'h0F00, ALU returns y=16'h0FF0 z=0 → req0_ready at T, alu_start at T+1, rsp0_valid at T+2 with rsp_y=16'h0FF0 rsp_z=0.
- Contention: both valid continuously from reset, rsp_ready tied 1 → grants alternate 0,1,0,1 across four ops; never two readys in one cycle.
- Latency, ALU_LAT=4: ALU returns y=0 z=1 → rsp1_valid exactly 5 cycles after accept; rsp_z=1 rsp_y=0.
- Backpressure: rsp0_ready held 0 for 10 cycles while req1_valid=1 → rsp0_valid and rsp_y stable, req1_ready stays 0; req1 accepted only on the cycle after rsp0 is consumed.
- Reset mid-op: rst_n low during WAIT → all outputs 0 immediately. After release, no response appears; a fresh req1 is accepted normally.
- ARB_STATS_EN: 3 ops on req0, 2 on req1 → gnt_cnt0=3, gnt_cnt1=2. Preload to 16'hFFFF and issue again → holds 16'hFFFF. stats_clr → both 0.

Source files
------------

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester round-robin arbiter and sequencer for the shared ALU
//
// Grants one operation at a time to requester 0 or 1, drives it onto the
// registered ALU operand bus with a one-cycle start pulse, waits ALU_LAT
// cycles, captures alu_y/alu_z and returns them on the granted requester's
// response channel through a one-deep response buffer.
//
// Optional feature macro: ARB_STATS_EN (adds saturating per-requester grant counters).
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   reqN_valid/ready/op/a/b          requester N command channel (N = 0, 1)
//   rspN_valid/ready                 requester N response channel
//   rsp_y, rsp_z                     captured result and zero flag (shared)
//   alu_start, alu_op, alu_a, alu_b  launch pulse and registered operands
//   alu_y, alu_z                     ALU result and zero flag
//   stats_clr, gnt_cnt0, gnt_cnt1    (ARB_STATS_EN) clear and grant counters
module alu_share_arb #(
  parameter int DW      = 16,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp_y,
  output logic           rsp_z,
`ifdef ARB_STATS_EN
  input  logic           stats_clr,
  output logic [15:0]    gnt_cnt0,
  output logic [15:0]    gnt_cnt1,
`endif
  output logic           alu_start,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_y,
  input  logic           alu_z
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          gnt_id_q;
  logic          last_gnt_q;
  logic          sel_id;
  logic          accept;
  logic          rsp_done;
  logic          cnt_zero;
  logic [CW-1:0] cnt_q;

  assign cnt_zero = (cnt_q == '0);

  // Round-robin pick: a lone requester wins; on contention the one not
  // granted last wins. last_gnt_q resets to 1 so requester 0 goes first.
  always_comb begin
    sel_id = 1'b0;
    if (req0_valid && req1_valid) begin
      sel_id = ~last_gnt_q;
    end else if (req1_valid) begin
      sel_id = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gated by rst_n so every output reads 0 while reset is held.
        req0_ready = rst_n & req0_valid & ~sel_id;
        req1_ready = rst_n & req1_valid &  sel_id;
        accept     = req0_ready | req1_ready;
        if (accept) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp0_valid = ~gnt_id_q;
        rsp1_valid =  gnt_id_q;
        rsp_done   = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
        // Returning to IDLE first keeps a new accept out of this cycle.
        if (rsp_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      gnt_id_q   <= 1'b0;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
      rsp_y      <= '0;
      rsp_z      <= 1'b0;
    end else begin
      // The launch register doubles as the first-WAIT-cycle marker.
      alu_start <= accept;
      if (accept) begin
        gnt_id_q <= sel_id;
        alu_op   <= sel_id ? req1_op : req0_op;
        alu_a    <= sel_id ? req1_a  : req0_a;
        alu_b    <= sel_id ? req1_b  : req0_b;
        cnt_q    <= CW'(ALU_LAT - 1);
      end else if (state_q == ST_WAIT && !cnt_zero) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == ST_WAIT && cnt_zero) begin
        rsp_y <= alu_y;
        rsp_z <= alu_z;
      end
      if (rsp_done) begin
        last_gnt_q <= gnt_id_q;
      end
    end
  end

`ifdef ARB_STATS_EN
  // Clear has priority over a same-cycle accept; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= 16'd0;
      gnt_cnt1 <= 16'd0;
    end else if (stats_clr) begin
      gnt_cnt0 <= 16'd0;
      gnt_cnt1 <= 16'd0;
    end else begin
      if (accept && !sel_id && gnt_cnt0 != 16'hFFFF) begin
        gnt_cnt0 <= gnt_cnt0 + 16'd1;
      end
      if (accept && sel_id && gnt_cnt1 != 16'hFFFF) begin
        gnt_cnt1 <= gnt_cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed scoreboard bench for alu_share_arb (ALU_LAT 1 and 4)
module tb_alu_share_arb;

  localparam int DW   = 16;
  localparam int OPW  = 3;
  localparam int LAT4 = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ALU_LAT = 1 instance
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OPW-1:0] req0_op, req1_op, alu_op;
  logic [DW-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic           rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0]  rsp_y, alu_a, alu_b, alu_y;
  logic           rsp_z, alu_start, alu_z;
`ifdef ARB_STATS_EN
  logic           stats_clr;
  logic [15:0]    gnt_cnt0, gnt_cnt1;
`endif

  // ALU_LAT = 4 instance
  logic           l_req0_valid, l_req0_ready, l_req1_valid, l_req1_ready;
  logic [OPW-1:0] l_req0_op, l_req1_op, l_alu_op;
  logic [DW-1:0]  l_req0_a, l_req0_b, l_req1_a, l_req1_b;
  logic           l_rsp0_valid, l_rsp0_ready, l_rsp1_valid, l_rsp1_ready;
  logic [DW-1:0]  l_rsp_y, l_alu_a, l_alu_b, l_alu_y;
  logic           l_rsp_z, l_alu_start, l_alu_z;
`ifdef ARB_STATS_EN
  logic           l_stats_clr;
  logic [15:0]    l_gnt_cnt0, l_gnt_cnt1;
`endif

  alu_share_arb #(.DW(DW), .OPW(OPW), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_y(rsp_y), .rsp_z(rsp_z),
`ifdef ARB_STATS_EN
    .stats_clr(stats_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .alu_z(alu_z)
  );

  alu_share_arb #(.DW(DW), .OPW(OPW), .ALU_LAT(LAT4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(l_req0_valid), .req0_ready(l_req0_ready), .req0_op(l_req0_op),
    .req0_a(l_req0_a), .req0_b(l_req0_b),
    .rsp0_valid(l_rsp0_valid), .rsp0_ready(l_rsp0_ready),
    .req1_valid(l_req1_valid), .req1_ready(l_req1_ready), .req1_op(l_req1_op),
    .req1_a(l_req1_a), .req1_b(l_req1_b),
    .rsp1_valid(l_rsp1_valid), .rsp1_ready(l_rsp1_ready),
    .rsp_y(l_rsp_y), .rsp_z(l_rsp_z),
`ifdef ARB_STATS_EN
    .stats_clr(l_stats_clr), .gnt_cnt0(l_gnt_cnt0), .gnt_cnt1(l_gnt_cnt1),
`endif
    .alu_start(l_alu_start), .alu_op(l_alu_op), .alu_a(l_alu_a), .alu_b(l_alu_b),
    .alu_y(l_alu_y), .alu_z(l_alu_z)
  );

  function automatic logic [DW-1:0] alu_f(input logic [OPW-1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a | b;
      3'd3:    return a & b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // ALU models drive a poison value outside the cycle in which the result
  // is valid, so a capture on the wrong cycle shows up as a data error.
  assign alu_y = alu_start ? alu_f(alu_op, alu_a, alu_b) : 16'hDEAD;
  assign alu_z = alu_start ? (alu_f(alu_op, alu_a, alu_b) == '0) : 1'b1;

  logic [3:0] l_age;
  logic       l_ok;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               l_age <= 4'd0;
    else if (l_alu_start)                     l_age <= 4'd1;
    else if (l_age != 4'd0 && l_age != 4'd15) l_age <= l_age + 4'd1;
  end
  assign l_ok    = (l_age == 4'(LAT4 - 1));
  assign l_alu_y = l_ok ? alu_f(l_alu_op, l_alu_a, l_alu_b) : 16'hDEAD;
  assign l_alu_z = l_ok ? (alu_f(l_alu_op, l_alu_a, l_alu_b) == '0) : 1'b1;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] y;
    logic          z;
  } exp_t;

  exp_t sb1[$];
  exp_t sb4[$];
  int   grant_log[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  int   fail_cnt = 0;

  function automatic exp_t mk(input logic id, input logic [DW-1:0] y);
    exp_t e;
    e.id = id;
    e.y  = y;
    e.z  = (y == '0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(inout exp_t q[$], input string tag, input logic id,
                         input logic [DW-1:0] y, input logic z);
    exp_t e;
    if (q.size() == 0) begin
      check({tag, "_unexpected_rsp"}, 1, 0);
    end else begin
      e = q.pop_front();
      check({tag, "_id"}, id, e.id);
      check({tag, "_y"}, y, e.y);
      check({tag, "_z"}, z, e.z);
    end
  endtask

  // One clock: observe handshakes of both DUTs (scoreboard push/pop), then
  // advance to just after the next falling edge.
  task automatic cyc();
    #1;
    if (req0_valid && req1_valid) check("one_ready", req0_ready & req1_ready, 0);
    if (req0_valid && req0_ready) begin
      sb1.push_back(mk(1'b0, alu_f(req0_op, req0_a, req0_b)));
      grant_log.push_back(0);
    end
    if (req1_valid && req1_ready) begin
      sb1.push_back(mk(1'b1, alu_f(req1_op, req1_a, req1_b)));
      grant_log.push_back(1);
    end
    if (l_req0_valid && l_req0_ready) sb4.push_back(mk(1'b0, alu_f(l_req0_op, l_req0_a, l_req0_b)));
    if (l_req1_valid && l_req1_ready) sb4.push_back(mk(1'b1, alu_f(l_req1_op, l_req1_a, l_req1_b)));
    if (rsp0_valid && rsp0_ready)     pop_cmp(sb1, "rsp_l1", 1'b0, rsp_y, rsp_z);
    if (rsp1_valid && rsp1_ready)     pop_cmp(sb1, "rsp_l1", 1'b1, rsp_y, rsp_z);
    if (l_rsp0_valid && l_rsp0_ready) pop_cmp(sb4, "rsp_l4", 1'b0, l_rsp_y, l_rsp_z);
    if (l_rsp1_valid && l_rsp1_ready) pop_cmp(sb4, "rsp_l4", 1'b1, l_rsp_y, l_rsp_z);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    l_req0_valid = 0; l_req1_valid = 0; l_rsp0_ready = 0; l_rsp1_ready = 0;
    sb1.delete(); sb4.delete(); grant_log.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic run_op1(input bit id, input logic [OPW-1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    bit hs;
    int n;
    rsp0_ready = 1; rsp1_ready = 1;
    if (id) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1; end
    else    begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1; end
    hs = 0; n = 0;
    while (!hs && n < 20) begin
      #1;
      hs = id ? req1_ready : req0_ready;
      cyc();
      n++;
    end
    req0_valid = 0; req1_valid = 0;
    check("op_accept", hs, 1);
    n = 0;
    while (sb1.size() != 0 && n < 20) begin cyc(); n++; end
    check("op_drain", sb1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    rst_n = 1'b0;
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0; rsp0_ready = 0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0; rsp1_ready = 0;
    l_req0_valid = 0; l_req0_op = '0; l_req0_a = '0; l_req0_b = '0; l_rsp0_ready = 0;
    l_req1_valid = 0; l_req1_op = '0; l_req1_a = '0; l_req1_b = '0; l_rsp1_ready = 0;
`ifdef ARB_STATS_EN
    stats_clr = 0; l_stats_clr = 0;
`endif

    // Reset state, with requests pending to show readies are held low.
    @(negedge clk);
    #1;
    req0_valid = 1; req1_valid = 1;
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    check("rst_rsp_y", rsp_y, 0);
    check("rst_rsp_z", rsp_z, 0);
    check("rst_alu", {alu_start, alu_op, alu_a, alu_b}, 0);
    req0_valid = 0; req1_valid = 0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Single op, ALU_LAT = 1.
    req0_op = 3'b010; req0_a = 16'h00F0; req0_b = 16'h0F00; req0_valid = 1;
    #1;
    check("t1_req0_ready", req0_ready, 1);
    check("t1_req1_ready", req1_ready, 0);
    cyc();
    req0_a = 16'hFFFF;  // still valid, new operands: must not be taken in WAIT
    #1;
    check("t1_start", alu_start, 1);
    check("t1_alu_op", alu_op, 3'b010);
    check("t1_alu_a", alu_a, 16'h00F0);
    check("t1_alu_b", alu_b, 16'h0F00);
    check("t1_wait_ready", req0_ready, 0);
    cyc();
    req0_valid = 0;
    check("t1_rsp0_valid", rsp0_valid, 1);
    check("t1_rsp1_valid", rsp1_valid, 0);
    check("t1_rsp_y", rsp_y, 16'h0FF0);
    check("t1_rsp_z", rsp_z, 0);
    check("t1_start_off", alu_start, 0);
    check("t1_alu_a_hold", alu_a, 16'h00F0);
    rsp0_ready = 1;
    cyc();
    rsp0_ready = 0;
    check("t1_drained", sb1.size(), 0);

    // Contention from reset: grants alternate 0,1,0,1.
    do_reset();
    req0_op = 3'd0; req0_a = 16'h0001; req0_b = 16'h0002;
    req1_op = 3'd4; req1_a = 16'h00FF; req1_b = 16'h00F0;
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    n = 0;
    while (grant_log.size() < 4 && n < 40) begin cyc(); n++; end
    req0_valid = 0; req1_valid = 0;
    check("t2_grants", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("t2_order", grant_log[i], i % 2);
    n = 0;
    while (sb1.size() != 0 && n < 20) begin cyc(); n++; end
    check("t2_drained", sb1.size(), 0);

    // Backpressure on rsp0 while req1 waits.
    rsp0_ready = 0; rsp1_ready = 1;
    req0_op = 3'd1; req0_a = 16'h0005; req0_b = 16'h0003; req0_valid = 1;
    #1;
    check("t3_accept0", req0_ready, 1);
    cyc();
    req0_valid = 0;
    req1_op = 3'd3; req1_a = 16'hF0F0; req1_b = 16'h0FF0; req1_valid = 1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      check("t3_rsp0_valid", rsp0_valid, 1);
      check("t3_rsp_y", rsp_y, 16'h0002);
      check("t3_req1_ready", req1_ready, 0);
      cyc();
    end
    rsp0_ready = 1;
    #1;
    check("t3_no_accept_on_rsp", req1_ready, 0);
    cyc();
    rsp0_ready = 0;
    check("t3_req1_ready_next", req1_ready, 1);
    cyc();
    req1_valid = 0;
    n = 0;
    while (sb1.size() != 0 && n < 20) begin cyc(); n++; end
    check("t3_drained", sb1.size(), 0);

    // Latency, ALU_LAT = 4: rsp1_valid exactly 5 cycles after accept.
    l_req1_op = 3'd3; l_req1_a = 16'h00F0; l_req1_b = 16'h0F00; l_req1_valid = 1;
    l_rsp1_ready = 0;
    #1;
    check("t4_accept1", l_req1_ready, 1);
    cyc();
    l_req1_valid = 0;
    n = 1;
    while (!l_rsp1_valid && n < 20) begin cyc(); n++; end
    check("t4_latency", n, 5);
    check("t4_rsp_y", l_rsp_y, 16'h0000);
    check("t4_rsp_z", l_rsp_z, 1);
    check("t4_rsp0_valid", l_rsp0_valid, 0);
    l_rsp1_ready = 1;
    cyc();
    l_rsp1_ready = 0;
    check("t4_drained", sb4.size(), 0);

    // Reset in the middle of a WAIT on the ALU_LAT = 4 instance.
    l_req0_op = 3'd0; l_req0_a = 16'h1111; l_req0_b = 16'h2222; l_req0_valid = 1;
    cyc();
    l_req0_valid = 0;
    cyc();
    rst_n = 1'b0;
    #1;
    check("t5_rst_alu", {l_alu_start, l_alu_op, l_alu_a, l_alu_b}, 0);
    check("t5_rst_rsp", {l_rsp0_valid, l_rsp1_valid, l_rsp_z}, 0);
    check("t5_rst_ready", {l_req0_ready, l_req1_ready}, 0);
    sb4.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    l_rsp0_ready = 1; l_rsp1_ready = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (l_rsp0_valid || l_rsp1_valid) seen = 1;
      cyc();
    end
    check("t5_no_rsp", seen, 0);
    l_req1_op = 3'd4; l_req1_a = 16'h1234; l_req1_b = 16'h1234; l_req1_valid = 1;
    #1;
    check("t5_fresh_accept", l_req1_ready, 1);
    cyc();
    l_req1_valid = 0;
    n = 0;
    while (sb4.size() != 0 && n < 20) begin cyc(); n++; end
    check("t5_drained", sb4.size(), 0);
    l_rsp0_ready = 0; l_rsp1_ready = 0;

`ifdef ARB_STATS_EN
    do_reset();
    check("st_rst", {gnt_cnt0, gnt_cnt1}, 0);
    for (int i = 0; i < 3; i++) run_op1(1'b0, 3'd0, 16'(i), 16'h0001);
    for (int i = 0; i < 2; i++) run_op1(1'b1, 3'd2, 16'(i), 16'h0100);
    check("st_cnt0", gnt_cnt0, 16'd3);
    check("st_cnt1", gnt_cnt1, 16'd2);
    force u_dut.gnt_cnt0 = 16'hFFFF;
    force u_dut.gnt_cnt1 = 16'hFFFF;
    @(negedge clk);
    #1;
    release u_dut.gnt_cnt0;
    release u_dut.gnt_cnt1;
    run_op1(1'b0, 3'd0, 16'h0001, 16'h0001);
    run_op1(1'b1, 3'd0, 16'h0001, 16'h0001);
    check("st_sat0", gnt_cnt0, 16'hFFFF);
    check("st_sat1", gnt_cnt1, 16'hFFFF);
    stats_clr = 1;
    cyc();
    stats_clr = 0;
    check("st_clr", {gnt_cnt0, gnt_cnt1}, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
